// File: rtl/scarv_cop_issue_ctrl.sv
// Issue/retire controller between the CPU/COP handshake and the NFU functional units.
// Handles one instruction at a time, with abort, optional timeout, illegal-dispatch detection and perf counters.
module scarv_cop_issue_ctrl #(
    parameter int         NFU         = 4,
    parameter int         TIMEOUT     = 0,
    parameter logic [2:0] RES_BAD_INS = 3'b001,
    parameter logic [2:0] RES_TIMEOUT = 3'b110,
    parameter logic [2:0] RES_ABORT   = 3'b111
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic               cpu_insn_req,
    output logic               cop_insn_ack,
    input  logic               cpu_abort_req,
    output logic               cop_insn_rsp,
    input  logic               cpu_insn_ack,
    input  logic               id_exception,
    input  logic [NFU-1:0]     id_fu_sel,
    input  logic               id_gpr_wen,
    input  logic [4:0]         id_rd,
    output logic [NFU-1:0]     fu_ivalid,
    input  logic [NFU-1:0]     fu_idone,
    input  logic [3*NFU-1:0]   fu_result,
    input  logic [31:0]        fu_gpr_wdata,
    output logic               cop_wen,
    output logic [4:0]         cop_waddr,
    output logic [31:0]        cop_wdata,
    output logic [2:0]         cop_result,
    output logic [31:0]        perf_retired,
    output logic [31:0]        perf_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAITING,
        S_EXECUTING,
        S_FINISHED
    } state_t;

    localparam logic [31:0] TLIM = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state, state_d;
    logic        ack_d, rsp_d;
    logic [31:0] tcnt;

    logic        accept, retire, executing, insn_valid;
    logic        sel_onehot, illegal;
    logic        bad_hit, done_hit, abort_hit, timeout_hit, finish;
    logic [2:0]  sel_res, result_d;

    assign accept     = cpu_insn_req & cop_insn_ack;
    assign retire     = cop_insn_rsp & cpu_insn_ack;
    assign executing  = (state == S_EXECUTING);
    assign insn_valid = accept | executing;

    // x & (x-1) clears the lowest set bit, so zero means at most one bit was set.
    assign sel_onehot = (id_fu_sel != '0) && ((id_fu_sel & (id_fu_sel - NFU'(1))) == '0);
    assign illegal    = id_exception | ~sel_onehot;

    assign fu_ivalid  = {NFU{insn_valid & ~illegal}} & id_fu_sel;

    assign bad_hit     = accept & illegal;
    assign done_hit    = insn_valid & |(fu_idone & id_fu_sel);
    assign abort_hit   = executing & cpu_abort_req;
    assign timeout_hit = (TIMEOUT != 0) && executing && (tcnt == TLIM);
    assign finish      = bad_hit | done_hit | abort_hit | timeout_hit;

    always_comb begin
        sel_res = '0;
        for (int i = 0; i < NFU; i++) begin
            if (id_fu_sel[i]) sel_res = sel_res | fu_result[3*i +: 3];
        end
    end

    // Completion outranks abort and timeout landing in the same cycle.
    always_comb begin
        if (bad_hit)        result_d = RES_BAD_INS;
        else if (done_hit)  result_d = sel_res;
        else if (abort_hit) result_d = RES_ABORT;
        else                result_d = RES_TIMEOUT;
    end

    always_comb begin
        state_d = state;
        ack_d   = cop_insn_ack;
        rsp_d   = cop_insn_rsp;
        case (state)
            S_IDLE: begin
                state_d = S_WAITING;
                ack_d   = 1'b1;
            end
            S_WAITING: begin
                ack_d = 1'b1;
                if (accept) begin
                    ack_d = 1'b0;
                    if (finish) begin
                        state_d = S_FINISHED;
                        rsp_d   = 1'b1;
                    end else begin
                        state_d = S_EXECUTING;
                    end
                end
            end
            S_EXECUTING: begin
                if (finish) begin
                    state_d = S_FINISHED;
                    rsp_d   = 1'b1;
                end
            end
            S_FINISHED: begin
                if (retire) begin
                    state_d = S_WAITING;
                    rsp_d   = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
                rsp_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state        <= S_IDLE;
            cop_insn_ack <= 1'b0;
            cop_insn_rsp <= 1'b0;
        end else begin
            state        <= state_d;
            cop_insn_ack <= ack_d;
            cop_insn_rsp <= rsp_d;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            tcnt <= '0;
        end else if (state_d == S_EXECUTING && state != S_EXECUTING) begin
            tcnt <= '0;
        end else if (executing) begin
            tcnt <= tcnt + 32'd1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            cop_wen    <= 1'b0;
            cop_waddr  <= '0;
            cop_wdata  <= '0;
            cop_result <= '0;
        end else if (finish) begin
            cop_wen    <= id_gpr_wen & (result_d == 3'b000);
            cop_waddr  <= id_rd;
            cop_wdata  <= fu_gpr_wdata;
            cop_result <= result_d;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            perf_retired <= '0;
            perf_busy    <= '0;
        end else begin
            if (retire)    perf_retired <= perf_retired + 32'd1;
            if (executing) perf_busy    <= perf_busy + 32'd1;
        end
    end

endmodule

// File: tb/tb_scarv_cop_issue_ctrl.sv
// Directed table-driven bench for scarv_cop_issue_ctrl (NFU=4, TIMEOUT=8).
module tb_scarv_cop_issue_ctrl;

    logic        g_clk, g_resetn;
    logic        cpu_insn_req, cop_insn_ack, cpu_abort_req, cop_insn_rsp, cpu_insn_ack;
    logic        id_exception, id_gpr_wen;
    logic [3:0]  id_fu_sel, fu_ivalid, fu_idone;
    logic [4:0]  id_rd, cop_waddr;
    logic [11:0] fu_result;
    logic [31:0] fu_gpr_wdata, cop_wdata, perf_retired, perf_busy;
    logic        cop_wen;
    logic [2:0]  cop_result;

    int checks = 0;
    int failures = 0;
    int cur_row = -1;

    scarv_cop_issue_ctrl #(.NFU(4), .TIMEOUT(8)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_abort_req(cpu_abort_req), .cop_insn_rsp(cop_insn_rsp),
        .cpu_insn_ack(cpu_insn_ack), .id_exception(id_exception),
        .id_fu_sel(id_fu_sel), .id_gpr_wen(id_gpr_wen), .id_rd(id_rd),
        .fu_ivalid(fu_ivalid), .fu_idone(fu_idone), .fu_result(fu_result),
        .fu_gpr_wdata(fu_gpr_wdata), .cop_wen(cop_wen), .cop_waddr(cop_waddr),
        .cop_wdata(cop_wdata), .cop_result(cop_result),
        .perf_retired(perf_retired), .perf_busy(perf_busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        req, abort, iack, exc;
        logic [3:0]  sel;
        logic        gwen;
        logic [4:0]  rd;
        logic [3:0]  idone;
        logic [11:0] fres;
        logic [31:0] wdata;
        logic        e_ack, e_rsp;
        logic [3:0]  e_iv;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [2:0]  e_res;
        logic [31:0] e_wdata, e_ret, e_busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(
        input logic req, abort, iack, exc, input logic [3:0] sel, input logic gwen,
        input logic [4:0] rd, input logic [3:0] idone, input logic [11:0] fres,
        input logic [31:0] wdata, input logic e_ack, e_rsp, input logic [3:0] e_iv,
        input logic e_wen, input logic [4:0] e_waddr, input logic [2:0] e_res,
        input logic [31:0] e_wdata, e_ret, e_busy);
        vec_t r;
        r.req = req; r.abort = abort; r.iack = iack; r.exc = exc; r.sel = sel;
        r.gwen = gwen; r.rd = rd; r.idone = idone; r.fres = fres; r.wdata = wdata;
        r.e_ack = e_ack; r.e_rsp = e_rsp; r.e_iv = e_iv; r.e_wen = e_wen;
        r.e_waddr = e_waddr; r.e_res = e_res; r.e_wdata = e_wdata;
        r.e_ret = e_ret; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h expected=%h", nm, cur_row, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        cpu_insn_req = r.req; cpu_abort_req = r.abort; cpu_insn_ack = r.iack;
        id_exception = r.exc; id_fu_sel = r.sel; id_gpr_wen = r.gwen; id_rd = r.rd;
        fu_idone = r.idone; fu_result = r.fres; fu_gpr_wdata = r.wdata;
    endtask

    task automatic check_row(input vec_t r);
        chk("ack",     32'(cop_insn_ack), 32'(r.e_ack));
        chk("rsp",     32'(cop_insn_rsp), 32'(r.e_rsp));
        chk("ivalid",  32'(fu_ivalid),    32'(r.e_iv));
        chk("wen",     32'(cop_wen),      32'(r.e_wen));
        chk("waddr",   32'(cop_waddr),    32'(r.e_waddr));
        chk("result",  32'(cop_result),   32'(r.e_res));
        chk("wdata",   cop_wdata,         r.e_wdata);
        chk("retired", perf_retired,      r.e_ret);
        chk("busy",    perf_busy,         r.e_busy);
    endtask

    initial begin
        vec_t idle;
        idle = v(0,0,0,0,4'h0,0,5'd0,4'h0,12'h0,32'h0, 0,0,4'h0,0,5'd0,3'd0,32'h0,0,0);

        // Outputs listed per row are the values seen during that cycle, before its edge.
        vq.push_back(idle);
        vq.push_back(v(1,0,0,0,4'b0100,1,5'd5,4'b0100,12'h0,32'hDEADBEEF, 1,0,4'b0100,0,5'd0,3'd0,32'h0,0,0));
        vq.push_back(v(0,0,0,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,1,5'd5,3'd0,32'hDEADBEEF,0,0));
        vq.push_back(v(0,0,0,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,1,5'd5,3'd0,32'hDEADBEEF,0,0));
        vq.push_back(v(0,0,1,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,1,5'd5,3'd0,32'hDEADBEEF,0,0));
        vq.push_back(v(0,0,0,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 1,0,4'b0000,1,5'd5,3'd0,32'hDEADBEEF,1,0));
        // Multi-cycle FU0, done on its 4th executing cycle with result 2.
        vq.push_back(v(1,0,0,0,4'b0001,1,5'd9,4'b0000,12'h0,32'h0, 1,0,4'b0001,1,5'd5,3'd0,32'hDEADBEEF,1,0));
        for (int k = 0; k < 3; k++)
            vq.push_back(v(0,0,0,0,4'b0001,1,5'd9,4'b0000,12'h0,32'h0, 0,0,4'b0001,1,5'd5,3'd0,32'hDEADBEEF,1,32'(k)));
        vq.push_back(v(0,0,0,0,4'b0001,1,5'd9,4'b0001,12'h002,32'h12345678, 0,0,4'b0001,1,5'd5,3'd0,32'hDEADBEEF,1,3));
        vq.push_back(v(0,0,0,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,0,5'd9,3'd2,32'h12345678,1,4));
        vq.push_back(v(0,0,1,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,0,5'd9,3'd2,32'h12345678,1,4));
        // Decode exception, then a two-hot select.
        vq.push_back(v(1,0,0,1,4'b0010,1,5'd3,4'b0000,12'h0,32'h0, 1,0,4'b0000,0,5'd9,3'd2,32'h12345678,2,4));
        vq.push_back(v(0,0,1,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,0,5'd3,3'd1,32'h0,2,4));
        vq.push_back(v(1,0,0,0,4'b0011,0,5'd4,4'b0011,12'h0,32'h0, 1,0,4'b0000,0,5'd3,3'd1,32'h0,3,4));
        vq.push_back(v(0,0,1,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,0,5'd4,3'd1,32'h0,3,4));
        // Abort at accept is ignored; abort on the 2nd executing cycle wins.
        vq.push_back(v(1,1,0,0,4'b1000,1,5'd7,4'b0000,12'h0,32'h0, 1,0,4'b1000,0,5'd4,3'd1,32'h0,4,4));
        vq.push_back(v(0,0,0,0,4'b1000,1,5'd7,4'b0000,12'h0,32'h0, 0,0,4'b1000,0,5'd4,3'd1,32'h0,4,4));
        vq.push_back(v(0,1,0,0,4'b1000,1,5'd7,4'b0000,12'h0,32'h0, 0,0,4'b1000,0,5'd4,3'd1,32'h0,4,5));
        vq.push_back(v(0,0,0,0,4'b1000,1,5'd7,4'b0000,12'h0,32'h0, 0,1,4'b0000,0,5'd7,3'd7,32'h0,4,6));
        vq.push_back(v(0,0,1,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,0,5'd7,3'd7,32'h0,4,6));
        // Abort coincident with done of FU1; a done on unselected FU3 carries result 5.
        vq.push_back(v(1,0,0,0,4'b0010,1,5'd2,4'b0000,12'h0,32'hA5A5A5A5, 1,0,4'b0010,0,5'd7,3'd7,32'h0,5,6));
        vq.push_back(v(0,1,0,0,4'b0010,1,5'd2,4'b1010,12'hA00,32'hA5A5A5A5, 0,0,4'b0010,0,5'd7,3'd7,32'h0,5,6));
        vq.push_back(v(0,0,0,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,1,5'd2,3'd0,32'hA5A5A5A5,5,7));
        vq.push_back(v(0,0,1,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,1,5'd2,3'd0,32'hA5A5A5A5,5,7));
        // Timeout after 8 executing cycles; stray done from FU0 must not finish FU2.
        vq.push_back(v(1,0,0,0,4'b0100,1,5'd1,4'b0000,12'h0,32'h0, 1,0,4'b0100,1,5'd2,3'd0,32'hA5A5A5A5,6,7));
        vq.push_back(v(0,0,0,0,4'b0100,1,5'd1,4'b0001,12'h0,32'h0, 0,0,4'b0100,1,5'd2,3'd0,32'hA5A5A5A5,6,7));
        for (int k = 1; k < 8; k++)
            vq.push_back(v(0,0,0,0,4'b0100,1,5'd1,4'b0000,12'h0,32'h0, 0,0,4'b0100,1,5'd2,3'd0,32'hA5A5A5A5,6,32'(7+k)));
        vq.push_back(v(0,0,0,0,4'b0100,1,5'd1,4'b0000,12'h0,32'h0, 0,1,4'b0000,0,5'd1,3'd6,32'h0,6,15));
        vq.push_back(v(0,0,1,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 0,1,4'b0000,0,5'd1,3'd6,32'h0,6,15));
        vq.push_back(v(0,0,0,0,4'b0000,0,5'd0,4'b0000,12'h0,32'h0, 1,0,4'b0000,0,5'd1,3'd6,32'h0,7,15));

        // Reset held for two edges.
        g_resetn = 1'b0;
        drive(idle);
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        #2;
        cur_row = -1;
        check_row(idle);
        g_resetn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            cur_row = i;
            drive(vq[i]);
            #2;
            check_row(vq[i]);
            @(negedge g_clk);
        end

        // Reset while executing: instruction dropped, counters cleared.
        cur_row = 100;
        drive(v(1,0,0,0,4'b0001,1,5'd6,4'b0000,12'h0,32'h0, 0,0,4'h0,0,5'd0,3'd0,32'h0,0,0));
        @(negedge g_clk);
        cpu_insn_req = 1'b0;
        #2;
        chk("mid_exec_ivalid", 32'(fu_ivalid), 32'h1);
        chk("mid_exec_ack", 32'(cop_insn_ack), 32'h0);
        g_resetn = 1'b0;
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        #2;
        cur_row = 101;
        check_row(v(0,0,0,0,4'h0,0,5'd0,4'h0,12'h0,32'h0, 0,0,4'h0,0,5'd0,3'd0,32'h0,0,0));
        fu_idone = 4'b0001;
        @(negedge g_clk);
        #2;
        cur_row = 102;
        chk("post_rst_ack1", 32'(cop_insn_ack), 32'h1);
        chk("post_rst_rsp1", 32'(cop_insn_rsp), 32'h0);
        @(negedge g_clk);
        #2;
        cur_row = 103;
        check_row(v(0,0,0,0,4'h0,0,5'd0,4'h0,12'h0,32'h0, 1,0,4'h0,0,5'd0,3'd0,32'h0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
